shim_integ_thresh_check: RTL and testbench
==========================================

SHIM_INTEG_THRESH_CHECK -- requirements
Module: shim_integ_thresh_check

Interface
REQ-001 Parameters: none SHALL be provided; all widths SHALL be fixed as listed below.
REQ-002 clk  in  1  single SPI-domain clock; all logic SHALL be on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 integ_en  in  1  integrator enable, already synchronized to clk.
REQ-005 integ_window  in  32  window length in accepted samples, already synchronized.
REQ-006 integ_thresh_avg  in  15  unsigned per-sample average-magnitude threshold, already synchronized.
REQ-007 sample  in  16  signed two's-complement sample.
REQ-008 sample_valid  in  1  sample qualifier; one sample accepted per cycle high.
REQ-009 window_done  out  1  one-cycle pulse at each completed window.
REQ-010 over_thresh  out  1  sticky fault: a window's magnitude sum exceeded the limit.
REQ-011 setup_err  out  1  sticky fault: integ_window was zero at enable.
REQ-012 state  out  2  current FSM state encoding.

Function
REQ-013 The FSM SHALL have states IDLE=0, SETUP=1, RUN=2, HALT=3.
REQ-014 IDLE: on integ_en high SHALL go to SETUP; over_thresh and setup_err SHALL clear on this transition.
REQ-015 SETUP (exactly one cycle): SHALL latch integ_window as win and limit = integ_thresh_avg * integ_window as a 47-bit unsigned product.
REQ-016 SETUP: SHALL clear the 48-bit accumulator and the 32-bit sample counter.
REQ-017 SETUP: if win == 0, SHALL set setup_err and go to HALT; otherwise SHALL go to RUN.
REQ-018 Samples presented in IDLE, SETUP or HALT SHALL be ignored.
REQ-019 Configuration input changes after SETUP SHALL have no effect until the next SETUP.
REQ-020 RUN, per accepted sample: acc += |sample|; |-32768| SHALL equal 32768; counter += 1.
REQ-021 When the accepted sample makes counter == win, the next cycle SHALL assert window_done for one cycle.
REQ-022 At window end, the compare SHALL use the final sum, including the last sample.
REQ-023 At window end, if acc > limit (strict), SHALL set over_thresh and go to HALT.
REQ-024 At window end, if acc <= limit, SHALL clear acc and counter in the same cycle and stay in RUN.
REQ-025 A sample_valid in the cycle following window end SHALL count toward the new window (no dead cycle).
REQ-026 win == 1 SHALL be legal: every accepted sample completes a window.
REQ-027 The accumulator SHALL never overflow: 32768 * (2^32-1) < 2^48.
REQ-028 HALT: SHALL hold over_thresh and setup_err and ignore samples until integ_en is low.
REQ-029 From any state, integ_en low SHALL force IDLE on the next edge and clear acc and counter.
REQ-030 Forcing IDLE SHALL leave over_thresh and setup_err unchanged.
REQ-031 If integ_en falls in the same cycle as a window-completing sample, integ_en SHALL win: no window_done and no compare.

Reset
REQ-032 On rst high, state SHALL be IDLE.
REQ-033 On rst high, acc, counter, win, limit, window_done, over_thresh and setup_err SHALL be 0.
REQ-034 rst asserted mid-window SHALL discard the partial sum with no window_done.

Configuration
REQ-035 Macro SHIM_INTEG_SUM_OUT_EN defined: SHALL add ports sum_last out 48 and sum_last_valid out 1.
REQ-036 With the macro, sum_last SHALL carry the final window sum and sum_last_valid SHALL pulse coincident with window_done.
REQ-037 With the macro, sum_last SHALL be 0 on reset.
REQ-038 Macro undefined: those ports and their registers SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-039 thresh=100, window=4, samples 100,-100,100,-100 -> window_done pulse, sum 400, over_thresh=0, state stays RUN.
REQ-040 thresh=100, window=4, samples 100,100,100,101 -> window_done, sum 401, over_thresh=1, state=HALT, later samples ignored.
REQ-041 window=0 with integ_en rising -> setup_err=1 after SETUP, state=HALT; drop integ_en -> IDLE with setup_err=1; re-raise integ_en -> setup_err clears.
REQ-042 window=1, thresh=0x7FFF, sample -32768 -> window_done, sum 32768, over_thresh=1.
REQ-043 window=3, thresh=10, back-to-back valid samples of 5 for 9 cycles -> three window_done pulses spaced 3 cycles apart, no fault.
REQ-044 rst after 2 of 4 samples -> no window_done, all outputs 0, state IDLE.

Source files
------------

// File: rtl/shim_integ_thresh_check_if.sv
// rtl/shim_integ_thresh_check_if.sv - configuration, sample and status bundle for the integrator threshold checker
interface shim_integ_thresh_check_if;
    logic        integ_en;
    logic [31:0] integ_window;
    logic [14:0] integ_thresh_avg;
    logic [15:0] sample;
    logic        sample_valid;
    logic        window_done;
    logic        over_thresh;
    logic        setup_err;
    logic [1:0]  state;

    modport master (
        output integ_en, integ_window, integ_thresh_avg, sample, sample_valid,
        input  window_done, over_thresh, setup_err, state
    );

    modport slave (
        input  integ_en, integ_window, integ_thresh_avg, sample, sample_valid,
        output window_done, over_thresh, setup_err, state
    );
endinterface

// File: rtl/shim_integ_thresh_check.sv
// rtl/shim_integ_thresh_check.sv - windowed |sample| integrator with sticky threshold fault; SHIM_INTEG_SUM_OUT_EN adds sum_last/sum_last_valid
module shim_integ_thresh_check (
    input  logic                        clk,
    input  logic                        rst,
    shim_integ_thresh_check_if.slave    bus
`ifdef SHIM_INTEG_SUM_OUT_EN
    ,
    output logic [47:0]                 sum_last,
    output logic                        sum_last_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] win;
    logic [46:0] limit;
    logic [47:0] acc;
    logic [31:0] cnt;
    logic        window_done_q;
    logic        over_thresh_q;
    logic        setup_err_q;

    logic [15:0] mag;
    logic [47:0] sum;
    logic [31:0] cnt_inc;
    logic        sum_over;
    logic        win_end;

    logic        do_setup;
    logic        do_accept;
    logic        do_clear;
    logic        clr_faults;

    // Two's-complement negate in 16 bits maps -32768 onto 0x8000, i.e. 32768 unsigned.
    assign mag      = bus.sample[15] ? (~bus.sample + 16'd1) : bus.sample;
    assign sum      = acc + {32'd0, mag};
    assign cnt_inc  = cnt + 32'd1;
    assign sum_over = sum > {1'b0, limit};
    assign win_end  = do_accept && (cnt_inc == win);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // integ_en low has priority over everything, including a window-completing sample.
    always_comb begin
        state_d    = state_q;
        do_setup   = 1'b0;
        do_accept  = 1'b0;
        do_clear   = 1'b0;
        clr_faults = 1'b0;
        if (!bus.integ_en) begin
            state_d  = IDLE;
            do_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = SETUP;
                    clr_faults = 1'b1;
                end
                SETUP: begin
                    do_setup = 1'b1;
                    state_d  = (bus.integ_window == 32'd0) ? HALT : RUN;
                end
                RUN: begin
                    if (bus.sample_valid) begin
                        do_accept = 1'b1;
                        if ((cnt_inc == win) && sum_over) begin
                            state_d = HALT;
                        end
                    end
                end
                default: begin
                    state_d = HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win           <= 32'd0;
            limit         <= 47'd0;
            acc           <= 48'd0;
            cnt           <= 32'd0;
            window_done_q <= 1'b0;
            over_thresh_q <= 1'b0;
            setup_err_q   <= 1'b0;
        end else begin
            window_done_q <= 1'b0;
            if (clr_faults) begin
                over_thresh_q <= 1'b0;
                setup_err_q   <= 1'b0;
            end
            if (do_clear) begin
                acc <= 48'd0;
                cnt <= 32'd0;
            end
            if (do_setup) begin
                win   <= bus.integ_window;
                limit <= 47'(bus.integ_thresh_avg) * 47'(bus.integ_window);
                acc   <= 48'd0;
                cnt   <= 32'd0;
                if (bus.integ_window == 32'd0) begin
                    setup_err_q <= 1'b1;
                end
            end
            if (do_accept) begin
                if (win_end) begin
                    window_done_q <= 1'b1;
                    acc           <= 48'd0;
                    cnt           <= 32'd0;
                    if (sum_over) begin
                        over_thresh_q <= 1'b1;
                    end
                end else begin
                    acc <= sum;
                    cnt <= cnt_inc;
                end
            end
        end
    end

`ifdef SHIM_INTEG_SUM_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_last       <= 48'd0;
            sum_last_valid <= 1'b0;
        end else begin
            sum_last_valid <= win_end;
            if (win_end) begin
                sum_last <= sum;
            end
        end
    end
`endif

    assign bus.window_done = window_done_q;
    assign bus.over_thresh = over_thresh_q;
    assign bus.setup_err   = setup_err_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_shim_integ_thresh_check.sv
// tb/tb_shim_integ_thresh_check.sv - directed scoreboard bench for shim_integ_thresh_check
module tb_shim_integ_thresh_check;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shim_integ_thresh_check_if bus ();

`ifdef SHIM_INTEG_SUM_OUT_EN
    logic [47:0] sum_last;
    logic        sum_last_valid;
`endif

    shim_integ_thresh_check dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave)
`ifdef SHIM_INTEG_SUM_OUT_EN
        ,
        .sum_last       (sum_last),
        .sum_last_valid (sum_last_valid)
`endif
    );

    typedef struct {
        longint sum;
        logic   over;
    } exp_t;

    exp_t   exp_q[$];
    int     n_total = 0;
    int     n_pass  = 0;
    int     cyc     = 0;
    int     done_cyc[$];

    longint m_acc;
    longint m_lim;
    longint m_win;
    longint m_cnt;
    bit     m_run;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.window_done === 1'b1) begin
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("window_done_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("window_over_thresh", 64'(bus.over_thresh), 64'(e.over));
`ifdef SHIM_INTEG_SUM_OUT_EN
                chk("window_sum_last", 64'(sum_last), 64'(e.sum));
                chk("window_sum_last_valid", 64'(sum_last_valid), 64'd1);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int unsigned w, input int unsigned thr);
        bus.integ_window     = w;
        bus.integ_thresh_avg = 15'(thr);
        bus.integ_en         = 1'b1;
        m_win = w;
        m_lim = longint'(thr) * longint'(w);
        m_acc = 0;
        m_cnt = 0;
        m_run = (w != 0);
        step();
        step();
    endtask

    task automatic drv(input logic signed [15:0] s);
        int a;
        bus.sample_valid = 1'b1;
        bus.sample       = s;
        if (m_run) begin
            a = s;
            if (a < 0) a = -a;
            m_acc += a;
            m_cnt++;
            if (m_cnt == m_win) begin
                exp_q.push_back('{sum: m_acc, over: (m_acc > m_lim)});
                if (m_acc > m_lim) m_run = 0;
                m_acc = 0;
                m_cnt = 0;
            end
        end
        step();
        bus.sample_valid = 1'b0;
    endtask

    task automatic stop();
        bus.integ_en = 1'b0;
        m_run = 0;
        step();
    endtask

    initial begin
        rst                  = 1'b1;
        bus.integ_en         = 1'b0;
        bus.integ_window     = 32'd0;
        bus.integ_thresh_avg = 15'd0;
        bus.sample           = 16'd0;
        bus.sample_valid     = 1'b0;
        m_run = 0;
        repeat (3) step();
        chk("rst_state", 64'(bus.state), 64'd0);
        chk("rst_window_done", 64'(bus.window_done), 64'd0);
        chk("rst_over_thresh", 64'(bus.over_thresh), 64'd0);
        chk("rst_setup_err", 64'(bus.setup_err), 64'd0);
`ifdef SHIM_INTEG_SUM_OUT_EN
        chk("rst_sum_last", 64'(sum_last), 64'd0);
`endif
        rst = 1'b0;
        step();

        // Balanced window, then a back-to-back second window (sum 10).
        start(4, 100);
        chk("run_entered", 64'(bus.state), 64'd2);
        drv(16'sd100); drv(-16'sd100); drv(16'sd100); drv(-16'sd100);
        drv(16'sd1); drv(16'sd2); drv(16'sd3); drv(16'sd4);
        step();
        chk("bal_over_thresh", 64'(bus.over_thresh), 64'd0);
        chk("bal_state_run", 64'(bus.state), 64'd2);
        chk("bal_queue_drained", 64'(exp_q.size()), 64'd0);
        stop();
        chk("idle_after_en_low", 64'(bus.state), 64'd0);

        // Sum 401 > 400: fault, HALT, later samples ignored.
        start(4, 100);
        drv(16'sd100); drv(16'sd100); drv(16'sd100); drv(16'sd101);
        chk("over_flag", 64'(bus.over_thresh), 64'd1);
        chk("over_state_halt", 64'(bus.state), 64'd3);
        repeat (5) drv(16'sd1000);
        chk("halt_holds_state", 64'(bus.state), 64'd3);
        chk("halt_holds_over", 64'(bus.over_thresh), 64'd1);
        stop();
        chk("forced_idle_keeps_over", 64'(bus.over_thresh), 64'd1);

        // Zero window at enable.
        bus.integ_window = 32'd0;
        bus.integ_en     = 1'b1;
        step();
        chk("setup_clears_over", 64'(bus.over_thresh), 64'd0);
        chk("setup_state", 64'(bus.state), 64'd1);
        step();
        chk("zero_win_setup_err", 64'(bus.setup_err), 64'd1);
        chk("zero_win_halt", 64'(bus.state), 64'd3);
        stop();
        chk("zero_win_idle", 64'(bus.state), 64'd0);
        chk("zero_win_err_kept", 64'(bus.setup_err), 64'd1);
        bus.integ_en = 1'b1;
        step();
        chk("reenable_clears_err", 64'(bus.setup_err), 64'd0);
        stop();

        // Single-sample window with the most negative sample.
        start(1, 32'h7FFF);
        drv(-16'sd32768);
        chk("min_sample_over", 64'(bus.over_thresh), 64'd1);
        chk("min_sample_halt", 64'(bus.state), 64'd3);
        stop();

        // Back-to-back windows of three.
        start(3, 10);
        done_cyc.delete();
        repeat (9) drv(16'sd5);
        step();
        chk("b2b_done_count", 64'(done_cyc.size()), 64'd3);
        if (done_cyc.size() == 3) begin
            chk("b2b_spacing_1", 64'(done_cyc[1] - done_cyc[0]), 64'd3);
            chk("b2b_spacing_2", 64'(done_cyc[2] - done_cyc[1]), 64'd3);
        end
        chk("b2b_no_fault", 64'(bus.over_thresh), 64'd0);
        stop();

        // integ_en falling with the window-completing sample wins.
        start(2, 0);
        drv(16'sd7);
        done_cyc.delete();
        bus.integ_en = 1'b0;
        m_run = 0;
        drv(16'sd7);
        step();
        chk("en_race_no_done", 64'(done_cyc.size()), 64'd0);
        chk("en_race_idle", 64'(bus.state), 64'd0);
        chk("en_race_no_over", 64'(bus.over_thresh), 64'd0);

        // Config changes after SETUP are ignored (limit stays 20).
        start(2, 10);
        bus.integ_window     = 32'd1;
        bus.integ_thresh_avg = 15'd0;
        done_cyc.delete();
        drv(16'sd5);
        chk("cfg_no_early_done", 64'(done_cyc.size()), 64'd0);
        drv(16'sd5);
        chk("cfg_latched_no_fault", 64'(bus.over_thresh), 64'd0);
        chk("cfg_latched_run", 64'(bus.state), 64'd2);
        stop();

        // Reset mid-window discards the partial sum.
        start(4, 100);
        drv(16'sd50); drv(16'sd50);
        done_cyc.delete();
        rst = 1'b1;
        bus.integ_en = 1'b0;
        m_run = 0;
        step();
        step();
        chk("midrst_no_done", 64'(done_cyc.size()), 64'd0);
        chk("midrst_state", 64'(bus.state), 64'd0);
        chk("midrst_over", 64'(bus.over_thresh), 64'd0);
        chk("midrst_err", 64'(bus.setup_err), 64'd0);
        chk("midrst_window_done", 64'(bus.window_done), 64'd0);
        rst = 1'b0;
        step();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
